// File: rtl/stats_wb_regs.sv
`timescale 1ns/1ps
// Wishbone register bank for the TX/RX statistics counters: counter readout,
// clear pulses back to the counter stage, and a maskable sticky wrap interrupt.
module stats_wb_regs #(
    parameter logic COR_DEFAULT = 1'b0
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [7:0]  wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_int_o,
    input  logic [31:0] stats_tx_octets,
    input  logic [31:0] stats_tx_pkts,
    input  logic [31:0] stats_rx_octets,
    input  logic [31:0] stats_rx_pkts,
    output logic        clear_stats_tx_octets,
    output logic        clear_stats_tx_pkts,
    output logic        clear_stats_rx_octets,
    output logic        clear_stats_rx_pkts
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_ACK  = 1'b1;

    localparam logic [5:0] W_TX_OCT = 6'h00;
    localparam logic [5:0] W_TX_PKT = 6'h01;
    localparam logic [5:0] W_RX_OCT = 6'h02;
    localparam logic [5:0] W_RX_PKT = 6'h03;
    localparam logic [5:0] W_CTRL   = 6'h04;
    localparam logic [5:0] W_STATUS = 6'h05;
    localparam logic [5:0] W_MASK   = 6'h06;

    logic [0:0]  state;
    logic        cor;
    logic [3:0]  wrap_status;
    logic [3:0]  wrap_mask;
    logic [3:0]  msb_d1;
    logic [3:0]  clr_d1;
    logic [3:0]  clr_q;
    logic [3:0]  clr_nxt;
    logic [3:0]  w1c;
    logic [3:0]  msb_now;
    logic [3:0]  wrap;
    logic [31:0] rdata;
    logic [5:0]  word;
    logic        access;
    logic        is_cnt;
    logic        unused_bits;

    assign word    = wb_adr_i[7:2];
    assign access  = (state == ST_IDLE) && wb_cyc_i && wb_stb_i;
    assign is_cnt  = (word[5:2] == 4'h0);
    assign msb_now = {stats_rx_pkts[31], stats_rx_octets[31],
                      stats_tx_pkts[31], stats_tx_octets[31]};

    // A falling MSB right after our own clear pulse is not a wrap.
    assign wrap = msb_d1 & ~msb_now & ~clr_d1;

    assign unused_bits = ^{wb_adr_i[1:0], wb_dat_i[31:4]};

    assign wb_ack_o              = (state == ST_ACK);
    assign clear_stats_tx_octets = clr_q[0];
    assign clear_stats_tx_pkts   = clr_q[1];
    assign clear_stats_rx_octets = clr_q[2];
    assign clear_stats_rx_pkts   = clr_q[3];

    always_comb begin
        rdata = 32'h0;
        case (word)
            W_TX_OCT: rdata = stats_tx_octets;
            W_TX_PKT: rdata = stats_tx_pkts;
            W_RX_OCT: rdata = stats_rx_octets;
            W_RX_PKT: rdata = stats_rx_pkts;
            W_CTRL:   rdata = {31'h0, cor};
            W_STATUS: rdata = {28'h0, wrap_status};
            W_MASK:   rdata = {28'h0, wrap_mask};
            default:  rdata = 32'h0;
        endcase
    end

    always_comb begin
        clr_nxt = 4'h0;
        w1c     = 4'h0;
        if (access) begin
            if (wb_we_i) begin
                if (is_cnt)
                    clr_nxt[word[1:0]] = 1'b1;
                if (word == W_CTRL && wb_dat_i[1])
                    clr_nxt = 4'hF;
                if (word == W_STATUS)
                    w1c = wb_dat_i[3:0];
            end else if (cor && is_cnt) begin
                clr_nxt[word[1:0]] = 1'b1;
            end
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state       <= ST_IDLE;
            wb_dat_o    <= 32'h0;
            wb_int_o    <= 1'b0;
            cor         <= COR_DEFAULT;
            wrap_status <= 4'h0;
            wrap_mask   <= 4'h0;
            msb_d1      <= 4'h0;
            clr_d1      <= 4'h0;
            clr_q       <= 4'h0;
        end else begin
            msb_d1      <= msb_now;
            clr_d1      <= clr_q;
            clr_q       <= clr_nxt;
            // Hardware set takes priority over a simultaneous W1C.
            wrap_status <= (wrap_status & ~w1c) | wrap;
            wb_int_o    <= |(wrap_status & wrap_mask);
            case (state)
                ST_IDLE: begin
                    if (access) begin
                        state    <= ST_ACK;
                        wb_dat_o <= wb_we_i ? 32'h0 : rdata;
                        if (wb_we_i && word == W_CTRL)
                            cor <= wb_dat_i[0];
                        if (wb_we_i && word == W_MASK)
                            wrap_mask <= wb_dat_i[3:0];
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stats_wb_regs.sv
`timescale 1ns/1ps
// Scoreboard bench for stats_wb_regs: directed scenarios plus a randomized
// register/counter sequence checked against a register-level model.
module tb_stats_wb_regs;

    typedef struct {
        bit          rd;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic        we = 1'b0;
    logic [7:0]  adr = 8'h0;
    logic [31:0] wdat = 32'h0;
    logic [31:0] rdat;
    logic        ack;
    logic        intr;
    logic [3:0]  clr;
    logic [31:0] cnt [4];
    logic        ld_en [4];
    logic [31:0] ld_val [4];
    logic [31:0] inc [4];

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;

    // reference model of the register state
    logic [31:0] m_cnt [4];
    logic        m_cor;
    logic [3:0]  m_status;
    logic [3:0]  m_mask;

    stats_wb_regs #(.COR_DEFAULT(1'b0)) dut (
        .wb_clk_i(clk),
        .wb_rst_i(rst),
        .wb_cyc_i(cyc),
        .wb_stb_i(stb),
        .wb_we_i(we),
        .wb_adr_i(adr),
        .wb_dat_i(wdat),
        .wb_dat_o(rdat),
        .wb_ack_o(ack),
        .wb_int_o(intr),
        .stats_tx_octets(cnt[0]),
        .stats_tx_pkts(cnt[1]),
        .stats_rx_octets(cnt[2]),
        .stats_rx_pkts(cnt[3]),
        .clear_stats_tx_octets(clr[0]),
        .clear_stats_tx_pkts(clr[1]),
        .clear_stats_rx_octets(clr[2]),
        .clear_stats_rx_pkts(clr[3])
    );

    always #5 clk = ~clk;

    // Counter stage: a clear replaces the count with this cycle's increment.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) cnt[i] <= 32'h0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (ld_en[i])       cnt[i] <= ld_val[i];
                else if (clr[i])    cnt[i] <= inc[i];
                else                cnt[i] <= cnt[i] + inc[i];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && ack) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ack", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.rd) check("rdata", rdat, e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "timeout");
    end

    task automatic load_cnt(input int i, input logic [31:0] v);
        @(negedge clk);
        ld_en[i]  = 1'b1;
        ld_val[i] = v;
        @(negedge clk);
        ld_en[i]  = 1'b0;
    endtask

    // One access; returns in the ack cycle (the clear-pulse cycle).
    task automatic bus(input logic w, input logic [7:0] a, input logic [31:0] d,
                       input logic [31:0] expect_rd, output logic [3:0] clr_seen);
        exp_t e;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d;
        e.rd = !w; e.data = expect_rd;
        exp_q.push_back(e);
        @(negedge clk);
        check("ack_latency", {31'h0, ack}, 32'd1);
        clr_seen = clr;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wait_neg(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    initial begin
        logic [3:0]  cs;
        logic [31:0] v;
        int          acks;
        for (int i = 0; i < 4; i++) begin
            ld_en[i] = 1'b0; ld_val[i] = 32'h0; inc[i] = 32'h0; m_cnt[i] = 32'h0;
        end
        m_cor = 1'b0; m_status = 4'h0; m_mask = 4'h0;

        wait_neg(3);
        check("rst_ack", {31'h0, ack}, 32'd0);
        check("rst_dat", rdat, 32'h0);
        check("rst_int", {31'h0, intr}, 32'd0);
        check("rst_clr", {28'h0, clr}, 32'h0);
        rst = 1'b0;
        bus(1'b0, 8'h10, 32'h0, 32'h0, cs);
        bus(1'b0, 8'h14, 32'h0, 32'h0, cs);
        bus(1'b0, 8'h18, 32'h0, 32'h0, cs);

        // cor=0 read: no clear pulse
        load_cnt(1, 32'h12);
        bus(1'b0, 8'h04, 32'h0, 32'h12, cs);
        check("nocor_clr", {28'h0, cs}, 32'h0);

        // cor=1 read with an increment landing in the clear cycle
        bus(1'b1, 8'h10, 32'h1, 32'h0, cs);
        load_cnt(2, 32'h5DC);
        bus(1'b0, 8'h08, 32'h0, 32'h5DC, cs);
        check("cor_clr", {28'h0, cs}, 32'h4);
        inc[2] = 32'h40;
        @(negedge clk);
        inc[2] = 32'h0;
        check("cor_clr_1cyc", {28'h0, clr}, 32'h0);
        bus(1'b0, 8'h08, 32'h0, 32'h40, cs);

        // genuine wrap sets sticky status and the interrupt
        load_cnt(0, 32'hFFFF_FFF0);
        bus(1'b1, 8'h18, 32'h1, 32'h0, cs);
        load_cnt(0, 32'h0000_0010);
        wait_neg(3);
        check("wrap_int", {31'h0, intr}, 32'd1);
        bus(1'b0, 8'h14, 32'h0, 32'h1, cs);
        wait_neg(2);
        bus(1'b0, 8'h14, 32'h0, 32'h1, cs);
        bus(1'b1, 8'h14, 32'h1, 32'h0, cs);
        check("w1c_int_hold", {31'h0, intr}, 32'd1);
        @(negedge clk);
        check("w1c_int_drop", {31'h0, intr}, 32'd0);
        bus(1'b0, 8'h14, 32'h0, 32'h0, cs);

        // MSB fall caused by our own clear is not a wrap
        bus(1'b1, 8'h18, 32'h3, 32'h0, cs);
        load_cnt(1, 32'h8000_0005);
        bus(1'b0, 8'h04, 32'h0, 32'h8000_0005, cs);
        check("cor_clr_txp", {28'h0, cs}, 32'h2);
        wait_neg(3);
        bus(1'b0, 8'h14, 32'h0, 32'h0, cs);
        check("selfclr_int", {31'h0, intr}, 32'd0);
        bus(1'b0, 8'h04, 32'h0, 32'h0, cs);

        // clear-all
        bus(1'b1, 8'h10, 32'h3, 32'h0, cs);
        check("clrall_pulse", {28'h0, cs}, 32'hF);
        @(negedge clk);
        check("clrall_1cyc", {28'h0, clr}, 32'h0);
        bus(1'b0, 8'h10, 32'h0, 32'h1, cs);
        bus(1'b0, 8'h08, 32'h0, 32'h0, cs);

        // held strobe on unmapped address: one ack every second cycle
        begin
            exp_t e;
            e.rd = 1'b1; e.data = 32'h0;
            for (int k = 0; k < 3; k++) exp_q.push_back(e);
        end
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 8'h40;
        acks = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (ack) acks++;
        end
        cyc = 1'b0; stb = 1'b0;
        check("held_stb_acks", acks, 32'd3);

        // reset in the middle of a cor read
        bus(1'b1, 8'h18, 32'hF, 32'h0, cs);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 8'h00;
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst_ack", {31'h0, ack}, 32'd0);
        check("midrst_clr", {28'h0, clr}, 32'h0);
        check("midrst_dat", rdat, 32'h0);
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        bus(1'b0, 8'h10, 32'h0, 32'h0, cs);
        bus(1'b0, 8'h18, 32'h0, 32'h0, cs);
        bus(1'b0, 8'h14, 32'h0, 32'h0, cs);
        check("midrst_int", {31'h0, intr}, 32'd0);

        // randomized sequence against the register model
        for (int n = 0; n < 60; n++) begin
            int op;
            int idx;
            logic [7:0] a;
            op  = $urandom_range(0, 5);
            idx = $urandom_range(0, 3);
            a   = 8'(idx * 4) | 8'($urandom_range(0, 3));
            case (op)
                0: begin
                    v = $urandom & 32'h7FFF_FFFF;
                    load_cnt(idx, v);
                    m_cnt[idx] = v;
                end
                1: begin
                    bus(1'b0, a, 32'h0, m_cnt[idx], cs);
                    check("rnd_rd_clr", {28'h0, cs}, m_cor ? (32'd1 << idx) : 32'd0);
                    if (m_cor) m_cnt[idx] = 32'h0;
                end
                2: begin
                    v = $urandom & 32'hFFFF_FFFD;
                    bus(1'b1, 8'h10, v, 32'h0, cs);
                    m_cor = v[0];
                    check("rnd_ctrl_clr", {28'h0, cs}, 32'h0);
                end
                3: begin
                    v = $urandom;
                    bus(1'b1, 8'h18, v, 32'h0, cs);
                    m_mask = v[3:0];
                end
                4: begin
                    if (idx == 0)      bus(1'b0, 8'h10, 32'h0, {31'h0, m_cor}, cs);
                    else if (idx == 1) bus(1'b0, 8'h14, 32'h0, {28'h0, m_status}, cs);
                    else if (idx == 2) bus(1'b0, 8'h18, 32'h0, {28'h0, m_mask}, cs);
                    else               bus(1'b0, 8'h7C, 32'h0, 32'h0, cs);
                end
                default: begin
                    bus(1'b1, a, $urandom, 32'h0, cs);
                    check("rnd_wr_clr", {28'h0, cs}, 32'd1 << idx);
                    m_cnt[idx] = 32'h0;
                end
            endcase
        end
        wait_neg(2);
        check("rnd_int", {31'h0, intr}, {31'h0, |(m_status & m_mask)});
        check("queue_drained", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
